led_blink_ctrl: RTL

- Sequencer for a single status LED, built around a shared tick prescaler.
- Accepts a start command with a mode (off / on / continuous blink / N-pulse burst) and drives led_out with tick-aligned timing.
- Reports busy, and emits a done pulse when a finite sequence completes.
- Sits between board control logic and the LED pin; replaces free-running blink counters.

---
 rtl/led_ctrl_pkg.sv | 51 +++++
 rtl/led_tick_gen.sv | 38 +++
 rtl/led_blink_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
// Shared encodings for the status LED sequencer:
//   mode_e  - command modes latched on an accepted start
//   state_e - sequencer FSM states (ST_GAP exists only when the
//             LED_BURST_REPEAT_EN macro is defined)
//   GAP_TICKS / GAP_W - length and counter width of the inter-burst gap
//   led_start() - LED level driven on the cycle after a start is accepted
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

`ifdef LED_BURST_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
`endif

    localparam int unsigned GAP_TICKS = 4;
    localparam int unsigned GAP_W     = 3;

    // A zero-length burst behaves like OFF, so it must not light the LED.
    function automatic logic led_start(input mode_e m, input logic len_nz);
        logic lit;
        lit = 1'b0;
        unique case (m)
            MODE_OFF:   lit = 1'b0;
            MODE_ON:    lit = 1'b1;
            MODE_BLINK: lit = 1'b1;
            MODE_BURST: lit = len_nz;
            default:    lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Shared tick prescaler: 25-bit counter running 0..CNT_MAX and wrapping to 0.
// Ports:
//   sys_clk - system clock (rising edge)
//   sys_rst - asynchronous active-low reset
//   clr     - synchronous clear; the counter restarts from 0 next cycle
//   tick    - high for exactly one cycle while the count equals CNT_MAX
// ---------------------------------------------------------------------------
module led_tick_gen #(
    parameter logic [24:0] CNT_MAX = 25'd24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    output logic tick
);

    logic [24:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 25'd1;
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/led_blink_ctrl.sv
// ---------------------------------------------------------------------------
// led_blink_ctrl
// Single status LED sequencer: OFF / ON / continuous BLINK / N-pulse BURST,
// with all timing aligned to a shared prescaler tick.
// Ports:
//   sys_clk   - system clock (rising edge)
//   sys_rst   - asynchronous active-low reset
//   start     - one-cycle command strobe, honoured only in IDLE
//   stop      - abort, honoured in any non-IDLE state
//   mode      - command mode (see led_ctrl_pkg::mode_e), latched on start
//   burst_len - BURST pulse count, latched on start
//   led_out   - registered LED drive
//   busy      - high whenever the sequencer is not IDLE
//   done      - one-cycle pulse on normal completion of a finite sequence
// Build option: LED_BURST_REPEAT_EN - a completed BURST waits GAP_TICKS
// ticks with the LED dark and then replays the same burst until stop.
// ---------------------------------------------------------------------------
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [24:0] CNT_MAX = 25'd24_999_999,
    parameter int unsigned BURST_W = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [BURST_W-1:0] burst_len,
    output logic               led_out,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic               led_q, led_d;
    logic               accept;
    logic               tick;
`ifdef LED_BURST_REPEAT_EN
    logic [GAP_W-1:0]   gap_q, gap_d;
`endif

    led_tick_gen #(
        .CNT_MAX (CNT_MAX)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (accept),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        pulse_d = pulse_q;
        led_d   = led_q;
        accept  = 1'b0;
`ifdef LED_BURST_REPEAT_EN
        gap_d   = gap_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    accept  = 1'b1;
                    mode_d  = mode_e'(mode);
                    len_d   = burst_len;
                    pulse_d = '0;
                    led_d   = led_start(mode_e'(mode), |burst_len);
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                unique case (mode_q)
                    MODE_OFF: begin
                        led_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                    MODE_ON: begin
                        led_d = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (tick) begin
                            led_d = ~led_q;
                        end
                    end
                    MODE_BURST: begin
                        // Completion is seen the cycle after the final falling
                        // edge; a zero-length burst satisfies it immediately.
                        if ((pulse_q == len_q) && !led_q) begin
                            state_d = ST_DONE;
                        end else if (tick) begin
                            led_d = ~led_q;
                            if (led_q) begin
                                pulse_d = pulse_q + BURST_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_DONE;
                    end
                endcase
            end

            ST_DONE: begin
                led_d   = 1'b0;
                pulse_d = '0;
`ifdef LED_BURST_REPEAT_EN
                if (mode_q == MODE_BURST) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

`ifdef LED_BURST_REPEAT_EN
            ST_GAP: begin
                led_d = 1'b0;
                if (tick) begin
                    if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
                        gap_d   = '0;
                        pulse_d = '0;
                        led_d   = |len_q;
                        state_d = ST_RUN;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
            end
        endcase

        // Abort overrides any tick or completion decided above.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            led_d   = 1'b0;
            pulse_d = '0;
`ifdef LED_BURST_REPEAT_EN
            gap_d   = '0;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            len_q   <= '0;
            pulse_q <= '0;
            led_q   <= 1'b0;
`ifdef LED_BURST_REPEAT_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            pulse_q <= pulse_d;
            led_q   <= led_d;
`ifdef LED_BURST_REPEAT_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign led_out = led_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule
